// File: rtl/exu_div_wb_buf_if.sv
// Divide writeback buffer bus: divider finish in, GPR write port out, decode query and status.
interface exu_div_wb_buf_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            div_finish_i;
  logic [XLEN-1:0] div_result_i;
  logic [AW-1:0]   div_rd_i;
  logic            div_kill_i;
  logic            port_busy_i;
  logic            wen_o;
  logic [AW-1:0]   waddr_o;
  logic [XLEN-1:0] wdata_o;
  logic [AW-1:0]   query_rs_i;
  logic            query_hit_o;
  logic [XLEN-1:0] query_data_o;
  logic            full_o;
  logic [CW-1:0]   count_o;
  logic            overflow_o;

  modport master (
    output div_finish_i, div_result_i, div_rd_i, div_kill_i, port_busy_i, query_rs_i,
    input  wen_o, waddr_o, wdata_o, query_hit_o, query_data_o, full_o, count_o, overflow_o
  );

  modport slave (
    input  div_finish_i, div_result_i, div_rd_i, div_kill_i, port_busy_i, query_rs_i,
    output wen_o, waddr_o, wdata_o, query_hit_o, query_data_o, full_o, count_o, overflow_o
  );
endinterface

// File: rtl/exu_div_wb_buf.sv
// In-order buffer holding divide results until the shared GPR write port is free.
// I0/I1 own the port whenever port_busy_i is set; decode gets a pending-rd query.
module exu_div_wb_buf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5
) (
  input logic             clk,
  input logic             rst,
  exu_div_wb_buf_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            overflow_q, overflow_d;

  logic            full_c;
  logic            push_c;
  logic            pop_c;
  logic            accept_c;
  logic            wen_c;
  logic [AW-1:0]   waddr_c;
  logic [XLEN-1:0] wdata_c;
  logic            hit_c;
  logic [XLEN-1:0] qdata_c;

  assign full_c   = (count_q == CW'(DEPTH));
  assign push_c   = bus.div_finish_i & ~bus.div_kill_i & (bus.div_rd_i != '0);
  assign wen_c    = (count_q != '0) & ~bus.port_busy_i;
  assign pop_c    = wen_c;
  // A full buffer still takes a finish when the head drains in the same cycle.
  assign accept_c = push_c & (~full_c | pop_c);

  always_comb begin
    waddr_c    = '0;
    wdata_c    = '0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (count_q != '0) begin
      waddr_c = rd_q[rd_ptr_q];
      wdata_c = data_q[rd_ptr_q];
    end
    if (pop_c)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (accept_c) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(accept_c) - CW'(pop_c);
    if (push_c & ~accept_c) overflow_d = 1'b1;
  end

  // Walk valid entries oldest to youngest so the youngest match is left standing.
  always_comb begin
    hit_c   = 1'b0;
    qdata_c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (bus.query_rs_i != '0) &&
          (rd_q[rd_ptr_q + PW'(k)] == bus.query_rs_i)) begin
        hit_c   = 1'b1;
        qdata_c = data_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (accept_c) begin
        rd_q[wr_ptr_q]   <= bus.div_rd_i;
        data_q[wr_ptr_q] <= bus.div_result_i;
      end
    end
  end

  assign bus.wen_o        = wen_c;
  assign bus.waddr_o      = waddr_c;
  assign bus.wdata_o      = wdata_c;
  assign bus.query_hit_o  = hit_c;
  assign bus.query_data_o = qdata_c;
  assign bus.full_o       = full_c;
  assign bus.count_o      = count_q;
  assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_exu_div_wb_buf.sv
// Directed vector bench for exu_div_wb_buf (DEPTH=2) plus an async reset sequence.
module tb_exu_div_wb_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exu_div_wb_buf_if #(.XLEN(32), .DEPTH(2), .AW(5)) bus ();
  exu_div_wb_buf #(.XLEN(32), .DEPTH(2), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        f;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        k;
    logic        b;
    logic [4:0]  q;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] qd;
    logic        full;
    logic [1:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic f, logic [31:0] res, logic [4:0] rd, logic k, logic b,
                              logic [4:0] q, logic wen, logic [4:0] wa, logic [31:0] wd,
                              logic hit, logic [31:0] qd, logic full, logic [1:0] cnt,
                              logic ovf);
    vec_t v;
    v.f = f; v.res = res; v.rd = rd; v.k = k; v.b = b; v.q = q;
    v.wen = wen; v.wa = wa; v.wd = wd; v.hit = hit; v.qd = qd;
    v.full = full; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic wen, input logic [4:0] wa,
                         input logic [31:0] wd, input logic hit, input logic [31:0] qd,
                         input logic full, input logic [1:0] cnt, input logic ovf);
    chk({tag, ".wen"},   32'(bus.wen_o),        32'(wen));
    chk({tag, ".waddr"}, 32'(bus.waddr_o),      32'(wa));
    chk({tag, ".wdata"}, bus.wdata_o,           wd);
    chk({tag, ".hit"},   32'(bus.query_hit_o),  32'(hit));
    chk({tag, ".qdata"}, bus.query_data_o,      qd);
    chk({tag, ".full"},  32'(bus.full_o),       32'(full));
    chk({tag, ".count"}, 32'(bus.count_o),      32'(cnt));
    chk({tag, ".ovf"},   32'(bus.overflow_o),   32'(ovf));
  endtask

  task automatic drive(input logic f, input logic [31:0] res, input logic [4:0] rd,
                       input logic k, input logic b, input logic [4:0] q);
    bus.div_finish_i = f;
    bus.div_result_i = res;
    bus.div_rd_i     = rd;
    bus.div_kill_i   = k;
    bus.port_busy_i  = b;
    bus.query_rs_i   = q;
  endtask

  initial begin
    // f  res   rd k b q | wen wa wd  hit qd  full cnt ovf
    // basic
    vecs.push_back(mk(1, 32'h80, 5, 0, 0, 5,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 5,  1, 5, 32'h80, 1, 32'h80, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 5,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    // port contention, busy for 3 cycles
    vecs.push_back(mk(1, 32'h80, 5, 0, 1, 5,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 1, 5,  0, 5, 32'h80, 1, 32'h80, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 1, 5,  0, 5, 32'h80, 1, 32'h80, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 1, 5,  0, 5, 32'h80, 1, 32'h80, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 5,  1, 5, 32'h80, 1, 32'h80, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 5,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    // same rd twice, then push while full with a pop
    vecs.push_back(mk(1, 32'hA,  7, 0, 1, 7,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(1, 32'hB,  7, 0, 1, 7,  0, 7, 32'hA,  1, 32'hA,  0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 1, 7,  0, 7, 32'hA,  1, 32'hB,  1, 2, 0));
    vecs.push_back(mk(1, 32'hC,  9, 0, 0, 7,  1, 7, 32'hA,  1, 32'hB,  1, 2, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 7,  1, 7, 32'hB,  1, 32'hB,  1, 2, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 9,  1, 9, 32'hC,  1, 32'hC,  0, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 9,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    // kill and x0
    vecs.push_back(mk(1, 32'h55, 8, 1, 0, 8,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(1, 32'h66, 0, 0, 0, 0,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 8,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    // fill and overflow
    vecs.push_back(mk(1, 32'h11, 3, 0, 1, 3,  0, 0, 32'h0,  0, 32'h0,  0, 0, 0));
    vecs.push_back(mk(1, 32'h22, 4, 0, 1, 3,  0, 3, 32'h11, 1, 32'h11, 0, 1, 0));
    vecs.push_back(mk(1, 32'h33, 6, 0, 1, 6,  0, 3, 32'h11, 0, 32'h0,  1, 2, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 1, 6,  0, 3, 32'h11, 0, 32'h0,  1, 2, 1));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 4,  1, 3, 32'h11, 1, 32'h22, 1, 2, 1));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 3,  1, 4, 32'h22, 0, 32'h0,  0, 1, 1));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 3,  0, 0, 32'h0,  0, 32'h0,  0, 0, 1));

    drive(0, 32'h0, 5'd0, 0, 0, 5'd0);
    #2;
    chk_all("reset_state", 0, 0, 32'h0, 0, 32'h0, 0, 2'd0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Inputs change on the falling edge; outputs sampled 1 time unit later.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].f, vecs[i].res, vecs[i].rd, vecs[i].k, vecs[i].b, vecs[i].q);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].hit,
              vecs[i].qd, vecs[i].full, vecs[i].cnt, vecs[i].ovf);
    end

    // Async reset with two entries buffered, asserted between edges.
    @(negedge clk);
    drive(1, 32'h77, 5'd10, 0, 1, 5'd10);
    @(negedge clk);
    drive(1, 32'h88, 5'd11, 0, 1, 5'd10);
    @(negedge clk);
    drive(0, 32'h0, 5'd0, 0, 0, 5'd10);
    #1;
    chk_all("pre_rst", 1, 5'd10, 32'h77, 1, 32'h77, 1, 2'd2, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_all("in_rst", 0, 0, 32'h0, 0, 32'h0, 0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d.wen", c),   32'(bus.wen_o),   32'h0);
      chk($sformatf("post_rst%0d.count", c), 32'(bus.count_o), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
